// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard sequencer for the 5-stage pipeline around the decode controller.
//   - Load-use: one bubble (Hazard=1) with PC and IF/ID held.
//   - Control transfer in ID: fetch/decode held until the branch or jump
//     resolves in MEM (CTRL_WAIT), so the target is fetched with no squash.
//   - Multi-cycle mul: front of the pipeline frozen while mul_cnt counts down.
//   Optional feature macro: BRANCH_PREDICT_NT_EN
//     When defined, fetch runs past control transfers (predict not-taken) and
//     a taken transfer resolving in MEM squashes IF/ID, ID/EX and EX/MEM.
//
// Ports
//   Clk, Rst_n               clock, async active-low reset
//   IF_ID_Opcode/Funct/Rs/Rt instruction fields of the instruction in ID
//   ID_EX_MemRead, ID_EX_Rt  load in EX and its destination register
//   ID_EX_IsMul              mul in EX
//   EX_MEM_Resolve/Redirect  branch/jump in MEM, and whether it changes PC
//   Hazard                   bubble request to the decode controller
//   PCWrite, IF_ID_Write     front-end register enables
//   EX_Stall                 hold ID/EX + mul operands, bubble into EX/MEM
//   Flush                    00 none, 01 NOP into IF/ID, 10 squash three stages
//   MulBusy                  multiply countdown nonzero
module pipeline_hazard_unit #(
  parameter int unsigned MUL_CYCLES = 4  // legal 1..15
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] IF_ID_Opcode,
  input  logic [5:0] IF_ID_Funct,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic       ID_EX_IsMul,
  input  logic       EX_MEM_Resolve,
  input  logic       EX_MEM_Redirect,
  output logic       Hazard,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       EX_Stall,
  output logic [1:0] Flush,
  output logic       MulBusy
);

  typedef enum logic {RUN = 1'b0, CTRL_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic       hazard;
    logic       pc_write;
    logic       if_id_write;
    logic       ex_stall;
    logic [1:0] flush;
  } ctrl_t;

  localparam logic [1:0] FLUSH_NONE = 2'b00;
  localparam logic [1:0] FLUSH_IFID = 2'b01;
  localparam logic [1:0] FLUSH_ALL  = 2'b10;

  localparam ctrl_t CTRL_IDLE = '{hazard: 1'b0, pc_write: 1'b1, if_id_write: 1'b1,
                                  ex_stall: 1'b0, flush: FLUSH_NONE};

  // MUL_CYCLES=1 means the multiplier finishes in one EX cycle: no countdown.
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] FN_JR      = 6'b001000;

  state_t     state, state_nxt;
  logic [3:0] mul_cnt, mul_cnt_nxt;
  ctrl_t      ctrl;

  // ---------------- decode of the instruction in ID ----------------
  logic ctl, uses_rt, lu, mul_start, redirect, ctl_entry;

  // Branches/jumps live in opcodes 1..7; jr is the only SPECIAL transfer.
  assign ctl = ((IF_ID_Opcode >= 6'd1) && (IF_ID_Opcode <= 6'd7)) ||
               ((IF_ID_Opcode == OP_SPECIAL) && (IF_ID_Funct == FN_JR));

  // R-type, beq/bne, mul and stores read rt; everything else treats rt as a
  // destination, so a match there is not a dependency.
  assign uses_rt = IF_ID_Opcode inside {6'd0, 6'd4, 6'd5, 6'd28, 6'd40, 6'd41, 6'd43};

  // $0 is never really written, so a load to $0 cannot create a hazard.
  assign lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
              ((ID_EX_Rt == IF_ID_Rs) || (uses_rt && (ID_EX_Rt == IF_ID_Rt)));

  assign mul_start = MUL_MULTI && ID_EX_IsMul && (mul_cnt == 4'd0);

`ifdef BRANCH_PREDICT_NT_EN
  // Predict not-taken: ctl in ID does not stall; only a taken transfer
  // reaching MEM costs anything.
  logic ctl_unused;
  assign redirect   = EX_MEM_Resolve && EX_MEM_Redirect;
  assign ctl_entry  = 1'b0;
  assign ctl_unused = ctl;
`else
  // Stall build: the redirect qualifier has no consumer.
  logic redirect_unused;
  assign redirect        = 1'b0;
  assign ctl_entry       = ctl;
  assign redirect_unused = EX_MEM_Redirect;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= RUN;
      mul_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  // ---------------- next state / outputs ----------------
  // Priority: redirect > multiply > CTRL_WAIT > load-use > ctl entry.
  always_comb begin
    ctrl        = CTRL_IDLE;
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;

    if (redirect) begin
      // Wrong-path work is squashed, including any mul still counting.
      ctrl.flush  = FLUSH_ALL;
      mul_cnt_nxt = 4'd0;
      state_nxt   = RUN;
    end else if (mul_cnt != 4'd0) begin
      // Freeze front end; state is held so a pending wait resumes afterwards.
      ctrl.ex_stall    = 1'b1;
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      mul_cnt_nxt      = mul_cnt - 4'd1;
    end else begin
      // The mul's own first EX cycle is not a stall; countdown starts next.
      if (mul_start) mul_cnt_nxt = MUL_LOAD;

      if (state == CTRL_WAIT) begin
        // Keep NOPs flowing into IF/ID; MEM supplies the PC on resolve.
        ctrl.flush = FLUSH_IFID;
        if (EX_MEM_Resolve) state_nxt = RUN;
        else                ctrl.pc_write = 1'b0;
      end else if (lu) begin
        // Bubble first; a ctl in ID is re-seen next cycle and entered then.
        ctrl.hazard      = 1'b1;
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_write = 1'b0;
      end else if (ctl_entry) begin
        // ctl advances to EX; the fall-through fetch is replaced by a NOP.
        ctrl.pc_write = 1'b0;
        ctrl.flush    = FLUSH_IFID;
        state_nxt     = CTRL_WAIT;
      end
    end
  end

  // While reset is held, state/mul_cnt are already cleared; masking the
  // input-dependent terms makes every output show its reset value at once.
  assign Hazard      = Rst_n & ctrl.hazard;
  assign PCWrite     = ~Rst_n | ctrl.pc_write;
  assign IF_ID_Write = ~Rst_n | ctrl.if_id_write;
  assign EX_Stall    = Rst_n & ctrl.ex_stall;
  assign Flush       = Rst_n ? ctrl.flush : FLUSH_NONE;
  assign MulBusy     = Rst_n & (mul_cnt != 4'd0);

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: constant vector table, hand-built
// multi-cycle sequences, and random stimulus against a reference model.
module tb_pipeline_hazard_unit;
  localparam int MC = 4;
`ifdef BRANCH_PREDICT_NT_EN
  localparam bit NT = 1'b1;
`else
  localparam bit NT = 1'b0;
`endif

  // {Hazard, PCWrite, IF_ID_Write, EX_Stall, Flush[1:0], MulBusy}
  typedef struct packed {
    logic hz; logic pcw; logic ifw; logic exs; logic [1:0] fl; logic mb;
  } out_t;

  localparam out_t IDLE = 7'b0110000;
  localparam out_t LU   = 7'b1000000;
  localparam out_t CTL  = 7'b0010010;  // ctl entry / waiting: PCWrite=0, Flush=01
  localparam out_t RES  = 7'b0110010;  // resolve in wait: PCWrite=1, Flush=01
  localparam out_t MUL  = 7'b0001001;
  localparam out_t RED  = 7'b0110100;  // predicted-wrong redirect
  localparam out_t CTL_E = NT ? IDLE : CTL;
  localparam out_t RR_RUN = NT ? RED : IDLE;
  localparam out_t RR_LU  = NT ? RED : LU;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] exrt;
    logic       mul, res, red;
    out_t       exp;
  } vec_t;

  logic       Clk = 1'b0, Rst_n = 1'b0;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, exrt;
  logic       mr, ismul, res, red;
  logic       Hazard, PCWrite, IF_ID_Write, EX_Stall, MulBusy;
  logic [1:0] Flush;
  logic       Hazard1, PCWrite1, IF_ID_Write1, EX_Stall1, MulBusy1;
  logic [1:0] Flush1;
  out_t       act, act1;

  int n_cmp = 0, n_bad = 0;
  vec_t vecs[$];

  pipeline_hazard_unit #(.MUL_CYCLES(MC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .IF_ID_Opcode(op), .IF_ID_Funct(fn), .IF_ID_Rs(rs),
    .IF_ID_Rt(rt), .ID_EX_MemRead(mr), .ID_EX_Rt(exrt), .ID_EX_IsMul(ismul),
    .EX_MEM_Resolve(res), .EX_MEM_Redirect(red), .Hazard(Hazard), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .EX_Stall(EX_Stall), .Flush(Flush), .MulBusy(MulBusy));

  pipeline_hazard_unit #(.MUL_CYCLES(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .IF_ID_Opcode(op), .IF_ID_Funct(fn), .IF_ID_Rs(rs),
    .IF_ID_Rt(rt), .ID_EX_MemRead(mr), .ID_EX_Rt(exrt), .ID_EX_IsMul(ismul),
    .EX_MEM_Resolve(res), .EX_MEM_Redirect(red), .Hazard(Hazard1), .PCWrite(PCWrite1),
    .IF_ID_Write(IF_ID_Write1), .EX_Stall(EX_Stall1), .Flush(Flush1), .MulBusy(MulBusy1));

  assign act  = {Hazard, PCWrite, IF_ID_Write, EX_Stall, Flush, MulBusy};
  assign act1 = {Hazard1, PCWrite1, IF_ID_Write1, EX_Stall1, Flush1, MulBusy1};

  always #5 Clk = ~Clk;

  task automatic check(input string name, input out_t a, input out_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got hz=%b pcw=%b ifw=%b exs=%b fl=%b mb=%b, want hz=%b pcw=%b ifw=%b exs=%b fl=%b mb=%b",
               name, a.hz, a.pcw, a.ifw, a.exs, a.fl, a.mb, e.hz, e.pcw, e.ifw, e.exs, e.fl, e.mb);
    end
  endtask

  task automatic drive(input logic [5:0] op_, input logic [5:0] fn_, input logic [4:0] rs_,
                       input logic [4:0] rt_, input logic mr_, input logic [4:0] exrt_,
                       input logic mul_, input logic res_, input logic red_);
    op = op_; fn = fn_; rs = rs_; rt = rt_; mr = mr_; exrt = exrt_;
    ismul = mul_; res = res_; red = red_;
  endtask

  task automatic zeros();
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One cycle: inputs already driven; check mid-cycle, then step past the edge.
  task automatic cyc(input string name, input out_t e);
    @(negedge Clk);
    check(name, act, e);
    @(posedge Clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic [5:0] op_, input logic [5:0] fn_,
                         input logic [4:0] rs_, input logic [4:0] rt_, input logic mr_,
                         input logic [4:0] exrt_, input logic mul_, input logic res_,
                         input logic red_, input out_t e);
    vec_t v;
    v.name = n; v.op = op_; v.fn = fn_; v.rs = rs_; v.rt = rt_; v.mr = mr_;
    v.exrt = exrt_; v.mul = mul_; v.res = res_; v.red = red_; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic pulse_reset();
    zeros();
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // m_wait: a control transfer has gone to EX and MEM has not resolved it.
  // m_mul : stall cycles still owed to a mul in EX.
  bit m_wait;
  int m_mul;
  int rt_ops[7] = '{0, 4, 5, 28, 40, 41, 43};

  function automatic bit f_ctl();
    return (op >= 1 && op <= 7) || (op == 0 && fn == 8);
  endfunction

  function automatic bit f_lu();
    bit src = 1'b0;
    foreach (rt_ops[k]) if (int'(op) == rt_ops[k]) src = 1'b1;
    return mr && exrt != 0 && (exrt == rs || (src && exrt == rt));
  endfunction

  function automatic out_t model_out();
    out_t o = IDLE;
    o.mb = (m_mul > 0);
    if (NT && res && red) o.fl = 2'b10;
    else if (m_mul > 0) begin o.exs = 1; o.pcw = 0; o.ifw = 0; end
    else if (m_wait) begin o.fl = 2'b01; o.pcw = res; end
    else if (f_lu()) begin o.hz = 1; o.pcw = 0; o.ifw = 0; end
    else if (!NT && f_ctl()) begin o.pcw = 0; o.fl = 2'b01; end
    return o;
  endfunction

  task automatic model_step();
    if (NT && res && red) begin m_mul = 0; m_wait = 0; end
    else if (m_mul > 0) m_mul = m_mul - 1;
    else begin
      if (ismul && MC > 1) m_mul = MC - 1;
      if (m_wait) m_wait = !res;
      else if (!NT && !f_lu() && f_ctl()) m_wait = 1'b1;
    end
  endtask

  logic [5:0] rnd_ops[12] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd7, 6'd8, 6'd28, 6'd35, 6'd40, 6'd43, 6'd63};
  logic [5:0] rnd_fns[3]  = '{6'd8, 6'd32, 6'd9};

  initial begin
    zeros();
    #2;
    check("reset_outputs", act, IDLE);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // ---------------- single-cycle vectors from RUN ----------------
    //       name             op     fn         rs    rt    mr    exrt  mul   res   red   expected
    add_vec("idle",           6'd0,  6'd0,      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    add_vec("lu_add_rs",      6'd0,  6'b100000, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU);
    add_vec("lu_dest_r0",     6'd0,  6'b100000, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    add_vec("lu_rtype_rt",    6'd0,  6'b100000, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU);
    add_vec("lu_sw_rt",       6'd43, 6'd0,      5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, LU);
    add_vec("no_lu_addi_rt",  6'd8,  6'd0,      5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, IDLE);
    add_vec("no_lu_memread0", 6'd0,  6'b100000, 5'd5, 5'd2, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, IDLE);
    add_vec("ctl_beq",        6'd4,  6'd0,      5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CTL_E);
    add_vec("ctl_jr",         6'd0,  6'b001000, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CTL_E);
    add_vec("ctl_op7",        6'd7,  6'd0,      5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CTL_E);
    add_vec("ctl_j",          6'd2,  6'd0,      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, CTL_E);
    add_vec("not_ctl_jalr",   6'd0,  6'b001001, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    add_vec("lu_beats_ctl",   6'd4,  6'd0,      5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU);
    add_vec("mul_first_cyc",  6'd0,  6'd0,      5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, IDLE);
    add_vec("redir_in_run",   6'd0,  6'd0,      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, RR_RUN);
    add_vec("redir_vs_lu",    6'd0,  6'b100000, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, RR_LU);

    foreach (vecs[k]) begin
      drive(vecs[k].op, vecs[k].fn, vecs[k].rs, vecs[k].rt, vecs[k].mr, vecs[k].exrt,
            vecs[k].mul, vecs[k].res, vecs[k].red);
      @(negedge Clk);
      check(vecs[k].name, act, vecs[k].exp);
      pulse_reset();
      @(posedge Clk);
      #1;
    end

    // ---------------- multiply: 3 stall cycles with MUL_CYCLES=4, none with 1 ----------------
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    check("mul_t0", act, IDLE);
    check("mul1_t0", act1, IDLE);
    @(posedge Clk);
    #1;
    zeros();
    for (int i = 0; i < MC - 1; i++) begin
      @(negedge Clk);
      check($sformatf("mul_busy_%0d", i), act, MUL);
      check($sformatf("mul1_busy_%0d", i), act1, IDLE);
      @(posedge Clk);
      #1;
    end
    cyc("mul_released", IDLE);

`ifndef BRANCH_PREDICT_NT_EN
    // ---------------- beq stall build ----------------
    drive(6'd4, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("beq_t", CTL);
    zeros();
    cyc("beq_t1_wait", CTL);
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("beq_t2_resolve", RES);
    zeros();
    cyc("beq_t3_run", IDLE);

    // ---------------- load-use and jr together ----------------
    drive(6'd0, 6'b001000, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("lu_jr_bubble", LU);
    drive(6'd0, 6'b001000, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lu_jr_enter", CTL);
    zeros();
    cyc("lu_jr_wait", CTL);
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("lu_jr_resolve", RES);
    zeros();
    cyc("lu_jr_run", IDLE);

    // ---------------- mul stall takes priority over CTRL_WAIT, wait survives ----------------
    drive(6'd5, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("mw_enter", CTL);
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("mw_mul_start", CTL);
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MC - 1; i++) cyc($sformatf("mw_stall_%0d", i), MUL);
    cyc("mw_resolve", RES);
    zeros();
    cyc("mw_run", IDLE);

    // ---------------- reset while waiting ----------------
    drive(6'd1, 6'd0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("rst_enter", CTL);
    zeros();
    @(negedge Clk);
    check("rst_pre_wait", act, CTL);
    Rst_n = 1'b0;
    #1;
    check("rst_in_wait", act, IDLE);
    #1;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    cyc("rst_run_after", IDLE);
`else
    // ---------------- predict not-taken ----------------
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("nt_mul_t0", IDLE);
    zeros();
    cyc("nt_mul_cnt3", MUL);
    drive(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("nt_redirect_cnt2", out_t'(7'b0110101));
    zeros();
    cyc("nt_mul_cleared", IDLE);
    drive(6'd4, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("nt_beq_no_stall", IDLE);
    zeros();
    cyc("nt_after_beq", IDLE);
`endif

    // ---------------- random against the reference model ----------------
    pulse_reset();
    m_wait = 1'b0;
    m_mul  = 0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      drive(rnd_ops[$urandom_range(0, 11)], rnd_fns[$urandom_range(0, 2)],
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 1)));
      @(negedge Clk);
      check($sformatf("rand_%0d", i), act, model_out());
      model_step();
      @(posedge Clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

- Sequences the 5-stage pipeline around the decode controller.
- Detects load-use hazards and drives the controller's `Hazard` bubble input.
- Holds fetch and decode while a branch or jump is in flight to the MEM stage, where control transfers resolve.
- Freezes the front of the pipeline while a multi-cycle `mul` occupies EX.

## Interface
- `MUL_CYCLES`, 4: cycles a `mul` (opcode 28) occupies EX; legal range is 1 to 15.
- `Clk` input 1: rising-edge clock.
- `Rst_n` input 1: asynchronous, active-low reset.
- `IF_ID_Opcode` input 6: instruction[31:26] of the instruction in ID.
- `IF_ID_Funct` input 6: instruction[5:0] of the instruction in ID.
- `IF_ID_Rs` input 5: source register rs of the instruction in ID.
- `IF_ID_Rt` input 5: source register rt of the instruction in ID.
- `ID_EX_MemRead` input 1: the instruction in EX is a load.
- `ID_EX_Rt` input 5: destination register of the load in EX.
- `ID_EX_IsMul` input 1: the instruction in EX is a `mul`.
- `EX_MEM_Resolve` input 1: a branch or jump is in MEM this cycle.
- `EX_MEM_Redirect` input 1: that branch or jump changes the PC (taken branch or jump).
- `Hazard` output 1: to the controller; forces all control signals to 0, inserting a bubble into ID/EX.
- `PCWrite` output 1: PC register enable.
- `IF_ID_Write` output 1: IF/ID register enable.
- `EX_Stall` output 1: holds ID/EX and the multiplier operands; loads a bubble into EX/MEM.
- `Flush` output 2: 00 none; 01 load NOP into IF/ID; 10 squash IF/ID, ID/EX and EX/MEM.
- `MulBusy` output 1: the multiply countdown is nonzero.

## Operation
- Registered state: `state` (RUN, CTRL_WAIT) and `mul_cnt`, 4 bits.
- Reset: `state`=RUN and `mul_cnt`=0. With all inputs at 0, the outputs are `Hazard`=0, `PCWrite`=1, `IF_ID_Write`=1, `EX_Stall`=0, `Flush`=00, `MulBusy`=0.
- All outputs are combinational from the registered state and the current inputs. `Rst_n` low mid-operation returns to the reset condition immediately; any in-flight wait is abandoned.
- A control transfer in ID (`ctl`) is any of:
  - opcode 1, 2, 3, 4, 5, 6 or 7;
  - opcode 0 with funct 001000 (`jr`).
- rt is a source (`uses_rt`) for opcodes 0, 4, 5, 28, 40, 41 and 43.
- Load-use (`lu`) is true when all of the following hold:
  - `ID_EX_MemRead`=1;
  - `ID_EX_Rt`≠0;
  - `ID_EX_Rt`==`IF_ID_Rs`, or `uses_rt` and `ID_EX_Rt`==`IF_ID_Rt`.
- Output priority (highest first): redirect, then multiply, then CTRL_WAIT, then load-use, then ctl entry.
  1. **Multiply.** When `ID_EX_IsMul`=1, `mul_cnt`=0 and `MUL_CYCLES`>1, `mul_cnt` loads `MUL_CYCLES`-1. While `mul_cnt`≠0:
     - `EX_Stall`=1, `PCWrite`=0, `IF_ID_Write`=0, `MulBusy`=1;
     - `mul_cnt` decrements each cycle;
     - `state` does not change.
  2. **CTRL_WAIT.** `PCWrite`=0 and `Flush`=01. When `EX_MEM_Resolve`=1: `PCWrite`=1 (the MEM stage supplies the PC), `Flush`=01, and the next state is RUN.
  3. **Load-use in RUN.** `Hazard`=1, `PCWrite`=0, `IF_ID_Write`=0 for one cycle. A ctl in ID is not accepted in that cycle.
  4. **ctl entry in RUN, no lu.** `PCWrite`=0, `Flush`=01; the ctl advances to EX and the next state is CTRL_WAIT.
- `EX_MEM_Redirect` is ignored unless `BRANCH_PREDICT_NT_EN` is defined.

## Timing
- Load-use penalty: 1 bubble.
- `mul` penalty: `MUL_CYCLES`-1 stall cycles. The instruction after `mul` enters EX `MUL_CYCLES` cycles after the `mul` does.
- Control transfer with ctl in ID at cycle t (stall build):
  - t: `Flush`=01, `PCWrite`=0;
  - t+1: CTRL_WAIT, `Flush`=01, `PCWrite`=0;
  - t+2: `Resolve`=1, `PCWrite`=1, `Flush`=01;
  - t+3: RUN, and the target is fetched;
  - penalty is 3 cycles.
- Simultaneous lu and ctl in ID: the load-use stall comes first and CTRL_WAIT is entered one cycle later.
- `mul_cnt` load and decrement never wrap; 0 is a hold.

## Configuration
- `BRANCH_PREDICT_NT_EN` defined:
  - CTRL_WAIT is unused and fetch continues past a ctl (predict not-taken).
  - `EX_MEM_Resolve`=1 and `EX_MEM_Redirect`=1 in the same cycle give `Flush`=10 and `PCWrite`=1.
  - This redirect has top priority: it clears `mul_cnt` to 0 and overrides `Hazard`.
  - A not-taken branch costs 0 cycles; a taken branch or jump costs 3.
- `BRANCH_PREDICT_NT_EN` undefined: stall build as described above; `Flush`=10 is never produced.

## Test plan
- **Reset:** `Rst_n`=0 asserted during CTRL_WAIT → outputs at reset values in the same cycle; `state`=RUN after release.
- **Load-use:** `lw $5` in EX, `add $6,$5,$2` in ID → exactly 1 cycle of `Hazard`=1, `PCWrite`=0, `IF_ID_Write`=0. With `$0` as the destination → no stall.
- **Multiply:** `ID_EX_IsMul` pulse, `MUL_CYCLES`=4 → `MulBusy`=1 and `EX_Stall`=1 for exactly 3 cycles, then released. With `MUL_CYCLES`=1 → no stall.
- **beq, stall build:** `beq` in ID at t, `EX_MEM_Resolve` at t+2 → `Flush`=01 at t..t+2, `PCWrite`=0 at t and t+1, `PCWrite`=1 at t+2, RUN at t+3.
- **Priority:** lu and `jr` in ID together → 1 load-use bubble first, then entry into CTRL_WAIT.
- **Predict not-taken (`BRANCH_PREDICT_NT_EN`):** `Resolve`=1 and `Redirect`=1 while `mul_cnt`=2 → `Flush`=10, `mul_cnt`=0 next cycle. With `Redirect`=0 → no stall cycles.
